// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the
// byte-enable decode used by stores.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = '0;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = '1;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_be.sv
// DEPTH x 32 data array: synchronous byte-enable write, asynchronous read.
module dmem_be #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: EX/MEM register, data-memory access with configurable
// latency/stall handshake, load extension and misalignment detection.
module mem_stage_ls
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_MEM_valid,
  input  logic        i_MEM_regWe,
  input  logic        i_MEM_dMemWe,
  input  logic        i_MEM_dMemRe,
  input  logic        i_MEM_sWD,
  input  logic [1:0]  i_MEM_size,
  input  logic        i_MEM_signed,
  input  logic [4:0]  i_MEM_WRA,
  input  logic [31:0] i_MEM_aluOut,
  input  logic [31:0] i_MEM_rd2,
  output logic        o_MEM_stall,
  output logic        o_MEM_valid,
  output logic        o_MEM_regWe,
  output logic        o_MEM_sWD,
  output logic [4:0]  o_MEM_WRA,
  output logic [31:0] o_MEM_aluOut,
  output logic [31:0] o_MEM_rData,
  output logic        o_MEM_misalign
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [3:0]  LAT = 4'(MEM_LAT);

  logic        valid_q, regWe_q, we_q, re_q, sWD_q, signed_q;
  logic [1:0]  size_q;
  logic [4:0]  wra_q;
  logic [31:0] alu_q, rd2_q;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        stall, last;
  logic        memop, is_load, mis_raw, mis, mem_go;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata, rword, shifted, rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= 1'b0;
      regWe_q  <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      sWD_q    <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      wra_q    <= '0;
      alu_q    <= '0;
      rd2_q    <= '0;
    end else if (!stall) begin
      valid_q  <= i_MEM_valid;
      regWe_q  <= i_MEM_regWe;
      we_q     <= i_MEM_dMemWe;
      re_q     <= i_MEM_dMemRe;
      sWD_q    <= i_MEM_sWD;
      signed_q <= i_MEM_signed;
      size_q   <= i_MEM_size;
      wra_q    <= i_MEM_WRA;
      alu_q    <= i_MEM_aluOut;
      rd2_q    <= i_MEM_rd2;
    end
  end

  assign memop   = valid_q & (we_q | re_q);
  assign is_load = memop & re_q & ~we_q;
  assign lane    = alu_q[1:0];

  always_comb begin
    mis_raw = 1'b0;
    case (size_q)
      SZ_HALF: mis_raw = alu_q[0];
      SZ_WORD: mis_raw = |alu_q[1:0];
      SZ_ILL:  mis_raw = 1'b1;
      default: mis_raw = 1'b0;
    endcase
  end

  assign mis    = memop & mis_raw;
  assign mem_go = memop & ~mis;

  // The capture cycle already stalls when latency is nonzero; WAIT then
  // counts MEM_LAT cycles, the last of which (cnt = 1) releases the stall
  // and performs the store.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_go) begin
          if (LAT == 4'd0) begin
            last = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          last    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wdata = rd2_q;
    case (size_q)
      SZ_BYTE: wdata = {4{rd2_q[7:0]}};
      SZ_HALF: wdata = {2{rd2_q[15:0]}};
      default: wdata = rd2_q;
    endcase
  end

  assign be = byte_en(size_q, lane);

  dmem_be #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk_i   (clk),
    .we_i    (mem_go & we_q & last),
    .be_i    (be),
    .addr_i  (alu_q[AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (rword)
  );

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    rdata = '0;
    case (size_q)
      SZ_BYTE: rdata = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: rdata = rword;
    endcase
  end

  assign o_MEM_stall    = stall;
  assign o_MEM_valid    = valid_q & ~stall;
  assign o_MEM_regWe    = valid_q & regWe_q & ~stall & ~mis;
  assign o_MEM_sWD      = sWD_q;
  assign o_MEM_WRA      = wra_q;
  assign o_MEM_aluOut   = alu_q;
  assign o_MEM_rData    = (is_load & ~mis) ? rdata : '0;
  assign o_MEM_misalign = mis;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: directed vector table, latency/reset sequences and
// random ops against a byte-level memory model, on MEM_LAT = 0 and 3 instances.
module tb_mem_stage_ls;

  typedef struct packed {
    logic        valid, regwe, we, re, swd;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  wra;
    logic [31:0] addr, wd;
  } req_t;

  typedef struct packed {
    logic        stall, valid, regwe, swd, mis;
    logic [4:0]  wra;
    logic [31:0] alu, rdata;
  } rsp_t;

  typedef struct {
    req_t        rq;
    logic        valid, regwe, mis, chk_rd;
    logic [31:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  req_t r0, r3;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat [2] = '{0, 3};
  logic [31:0] mdl [2][16];

  logic        s0, v0, we0, sw0, m0, s3, v3, we3, sw3, m3;
  logic [4:0]  wra0, wra3;
  logic [31:0] alu0, rd0, alu3, rd3;

  mem_stage_ls #(.DEPTH(1024), .MEM_LAT(0)) u_lat0 (
    .clk(clk), .rstn(rstn),
    .i_MEM_valid(r0.valid), .i_MEM_regWe(r0.regwe), .i_MEM_dMemWe(r0.we),
    .i_MEM_dMemRe(r0.re), .i_MEM_sWD(r0.swd), .i_MEM_size(r0.size),
    .i_MEM_signed(r0.sgn), .i_MEM_WRA(r0.wra), .i_MEM_aluOut(r0.addr),
    .i_MEM_rd2(r0.wd),
    .o_MEM_stall(s0), .o_MEM_valid(v0), .o_MEM_regWe(we0), .o_MEM_sWD(sw0),
    .o_MEM_WRA(wra0), .o_MEM_aluOut(alu0), .o_MEM_rData(rd0), .o_MEM_misalign(m0)
  );

  mem_stage_ls #(.DEPTH(1024), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rstn(rstn),
    .i_MEM_valid(r3.valid), .i_MEM_regWe(r3.regwe), .i_MEM_dMemWe(r3.we),
    .i_MEM_dMemRe(r3.re), .i_MEM_sWD(r3.swd), .i_MEM_size(r3.size),
    .i_MEM_signed(r3.sgn), .i_MEM_WRA(r3.wra), .i_MEM_aluOut(r3.addr),
    .i_MEM_rd2(r3.wd),
    .o_MEM_stall(s3), .o_MEM_valid(v3), .o_MEM_regWe(we3), .o_MEM_sWD(sw3),
    .o_MEM_WRA(wra3), .o_MEM_aluOut(alu3), .o_MEM_rData(rd3), .o_MEM_misalign(m3)
  );

  function automatic rsp_t get_rsp(input int k);
    rsp_t r;
    if (k == 0) r = '{s0, v0, we0, sw0, m0, wra0, alu0, rd0};
    else        r = '{s3, v3, we3, sw3, m3, wra3, alu3, rd3};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int k, input req_t rq);
    if (k == 0) r0 = rq;
    else        r3 = rq;
  endtask

  // Present an op just after a posedge, then follow it until its result
  // cycle; stall cycles are counted and must show a WB bubble.
  task automatic run_op(input int k, input req_t rq, output rsp_t rs, output int nst);
    rsp_t cur;
    drive(k, rq);
    @(posedge clk); #1;
    nst = 0;
    cur = get_rsp(k);
    while (cur.stall && nst < 20) begin
      chk("bubble_valid_regwe", {30'd0, cur.valid, cur.regwe}, 32'd0);
      @(posedge clk); #1;
      nst++;
      cur = get_rsp(k);
    end
    if (nst >= 20) chk("stall_timeout", 32'(nst), 32'd19);
    rs = cur;
  endtask

  function automatic req_t mkreq(input logic we, input logic re, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic regwe);
    req_t r;
    r.valid = 1'b1; r.regwe = regwe; r.we = we; r.re = re; r.swd = re;
    r.size = size;  r.sgn = sgn;     r.wra = 5'd7 + {4'd0, we};
    r.addr = addr;  r.wd = wd;
    return r;
  endfunction

  function automatic vec_t mkvec(input req_t rq, input logic valid, input logic regwe,
                                 input logic mis, input logic chk_rd, input logic [31:0] rdata);
    vec_t v;
    v.rq = rq; v.valid = valid; v.regwe = regwe; v.mis = mis;
    v.chk_rd = chk_rd; v.rdata = rdata;
    return v;
  endfunction

  function automatic logic [31:0] model_load(input int k, input req_t rq);
    logic [31:0] w, sh, v;
    w  = mdl[k][(rq.addr >> 2) % 1024];
    sh = w >> (8 * (rq.addr % 4));
    if (rq.size == 2'd0) begin
      v = sh & 32'hFF;
      if (rq.sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (rq.size == 2'd1) begin
      v = sh & 32'hFFFF;
      if (rq.sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_store(input int k, input req_t rq);
    int unsigned idx, ln;
    logic [31:0] w;
    logic [7:0]  bv;
    idx = (rq.addr >> 2) % 1024;
    ln  = rq.addr % 4;
    w   = mdl[k][idx];
    for (int unsigned b = 0; b < 4; b++) begin
      if (rq.size == 2'd0 && b == ln) begin
        w[8*b +: 8] = rq.wd[7:0];
      end else if (rq.size == 2'd1 && b / 2 == ln / 2) begin
        bv = rq.wd[8*(b%2) +: 8];
        w[8*b +: 8] = bv;
      end else if (rq.size == 2'd2) begin
        w[8*b +: 8] = rq.wd[8*b +: 8];
      end
    end
    mdl[k][idx] = w;
  endtask

  task automatic check_model(input int k, input req_t rq, input rsp_t rs, input int nst);
    logic memop, mis;
    memop = rq.valid && (rq.we || rq.re);
    mis   = memop && (rq.size == 2'd3 || (rq.size == 2'd1 && rq.addr[0]) ||
                      (rq.size == 2'd2 && rq.addr[1:0] != 2'd0));
    chk("rnd_stall_cycles", 32'(nst), (memop && !mis) ? 32'(lat[k]) : 32'd0);
    chk("rnd_valid", {31'd0, rs.valid}, {31'd0, rq.valid});
    chk("rnd_regwe", {31'd0, rs.regwe}, {31'd0, rq.regwe && rq.valid && !mis});
    chk("rnd_misalign", {31'd0, rs.mis}, {31'd0, mis});
    chk("rnd_swd_wra", {26'd0, rs.swd, rs.wra}, {26'd0, rq.swd, rq.wra});
    chk("rnd_aluout", rs.alu, rq.addr);
    if (!mis) begin
      if (memop && rq.re && !rq.we) chk("rnd_rdata_load", rs.rdata, model_load(k, rq));
      else                          chk("rnd_rdata_zero", rs.rdata, 32'd0);
    end
    if (memop && rq.we && !mis) model_store(k, rq);
  endtask

  initial begin
    vec_t tbl[$];
    rsp_t rs;
    req_t rq;
    int   nst;

    r0 = '0; r3 = '0; rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rs = get_rsp(0);
    chk("reset_outputs_lat0", {rs.stall, rs.valid, rs.regwe, rs.swd, rs.mis, rs.wra} ^ 10'd0 ^ rs.alu ^ rs.rdata, 32'd0);
    chk("reset_rdata_lat0", rs.rdata | rs.alu, 32'd0);
    rs = get_rsp(1);
    chk("reset_outputs_lat3", {22'd0, rs.stall, rs.valid, rs.regwe, rs.swd, rs.mis, rs.wra}, 32'd0);
    chk("reset_rdata_lat3", rs.rdata | rs.alu, 32'd0);
    rstn = 1'b1;

    // Directed table on the zero-latency instance.
    tbl.push_back(mkvec(mkreq(1, 0, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0), 1, 0, 0, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd2, 0, 32'h10, 32'h0, 1),         1, 1, 0, 1, 32'hDEAD_BEEF));
    tbl.push_back(mkvec(mkreq(1, 0, 2'd0, 0, 32'h13, 32'h1234_5680, 0), 1, 0, 0, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd0, 1, 32'h13, 32'h0, 1),         1, 1, 0, 1, 32'hFFFF_FF80));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd0, 0, 32'h13, 32'h0, 1),         1, 1, 0, 1, 32'h0000_0080));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd2, 0, 32'h10, 32'h0, 1),         1, 1, 0, 1, 32'h80AD_BEEF));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd1, 1, 32'h12, 32'h0, 1),         1, 1, 0, 1, 32'hFFFF_80AD));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd1, 0, 32'h12, 32'h0, 1),         1, 1, 0, 1, 32'h0000_80AD));
    tbl.push_back(mkvec(mkreq(1, 0, 2'd2, 0, 32'h20, 32'hCAFE_F00D, 0), 1, 0, 0, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(1, 0, 2'd1, 0, 32'h22, 32'hABCD_1234, 0), 1, 0, 0, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd1, 1, 32'h22, 32'h0, 1),         1, 1, 0, 1, 32'h0000_1234));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd2, 0, 32'h20, 32'h0, 1),         1, 1, 0, 1, 32'h1234_F00D));
    tbl.push_back(mkvec(mkreq(1, 0, 2'd2, 0, 32'h00, 32'h0102_0304, 0), 1, 0, 0, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(1, 0, 2'd2, 0, 32'h01, 32'hFFFF_FFFF, 0), 1, 0, 1, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd2, 0, 32'h00, 32'h0, 1),         1, 1, 0, 1, 32'h0102_0304));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd2, 0, 32'h02, 32'h0, 1),         1, 0, 1, 0, 32'h0));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd3, 0, 32'h10, 32'h0, 1),         1, 0, 1, 0, 32'h0));
    tbl.push_back(mkvec(mkreq(1, 1, 2'd2, 0, 32'h1000, 32'h5555_AAAA, 1), 1, 1, 0, 1, 32'h0));
    tbl.push_back(mkvec(mkreq(0, 1, 2'd2, 0, 32'h00, 32'h0, 1),         1, 1, 0, 1, 32'h5555_AAAA));
    tbl.push_back(mkvec(mkreq(0, 0, 2'd3, 0, 32'h13, 32'h0, 1),         1, 1, 0, 1, 32'h0));
    rq = mkreq(0, 1, 2'd2, 0, 32'h10, 32'h0, 1);
    rq.valid = 1'b0;
    tbl.push_back(mkvec(rq, 0, 0, 0, 1, 32'h0));

    foreach (tbl[i]) begin
      run_op(0, tbl[i].rq, rs, nst);
      chk($sformatf("tbl%0d_stall_cycles", i), 32'(nst), 32'd0);
      chk($sformatf("tbl%0d_valid", i), {31'd0, rs.valid}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_regwe", i), {31'd0, rs.regwe}, {31'd0, tbl[i].regwe});
      chk($sformatf("tbl%0d_misalign", i), {31'd0, rs.mis}, {31'd0, tbl[i].mis});
      chk($sformatf("tbl%0d_aluout", i), rs.alu, tbl[i].rq.addr);
      chk($sformatf("tbl%0d_wra", i), {27'd0, rs.wra}, {27'd0, tbl[i].rq.wra});
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rs.rdata, tbl[i].rdata);
    end

    // Latency-3 sequences.
    r0 = '0;
    run_op(1, mkreq(1, 0, 2'd2, 0, 32'h40, 32'h1111_1111, 0), rs, nst);
    chk("lat3_store_stall_cycles", 32'(nst), 32'd3);
    chk("lat3_store_valid", {31'd0, rs.valid}, 32'd1);
    run_op(1, mkreq(0, 1, 2'd2, 0, 32'h40, 32'h0, 1), rs, nst);
    chk("lat3_load_stall_cycles", 32'(nst), 32'd3);
    chk("lat3_load_valid_regwe", {30'd0, rs.valid, rs.regwe}, 32'd3);
    chk("lat3_load_rdata", rs.rdata, 32'h1111_1111);
    run_op(1, mkreq(0, 0, 2'd2, 0, 32'h44, 32'h0, 1), rs, nst);
    chk("lat3_nonmem_stall_cycles", 32'(nst), 32'd0);
    run_op(1, mkreq(0, 1, 2'd2, 0, 32'h42, 32'h0, 1), rs, nst);
    chk("lat3_misalign_stall_cycles", 32'(nst), 32'd0);
    chk("lat3_misalign_flags", {30'd0, rs.mis, rs.regwe}, 32'd2);

    // Reset pulse in the second WAIT cycle of a store.
    drive(1, mkreq(1, 0, 2'd2, 0, 32'h40, 32'h55AA_55AA, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_wait_stall_before", {31'd0, s3}, 32'd1);
    rstn = 1'b0;
    #1;
    rs = get_rsp(1);
    chk("rst_wait_ctrl_outputs", {22'd0, rs.stall, rs.valid, rs.regwe, rs.swd, rs.mis, rs.wra}, 32'd0);
    chk("rst_wait_data_outputs", rs.alu | rs.rdata, 32'd0);
    r3 = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    run_op(1, mkreq(0, 1, 2'd2, 0, 32'h1040, 32'h0, 1), rs, nst);
    chk("rst_wait_old_word_alias", rs.rdata, 32'h1111_1111);
    chk("rst_wait_reload_stall_cycles", 32'(nst), 32'd3);

    // Randomized ops against the memory model on both instances.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) r3 = '0;
      else        r0 = '0;
      for (int w = 0; w < 16; w++) begin
        rq = mkreq(1, 0, 2'd2, 0, 32'(w * 4), $urandom, 0);
        run_op(k, rq, rs, nst);
        check_model(k, rq, rs, nst);
      end
      for (int n = 0; n < 150; n++) begin
        rq.valid = ($urandom_range(7) != 0);
        rq.regwe = 1'($urandom);
        rq.we    = 1'($urandom);
        rq.re    = 1'($urandom);
        rq.swd   = 1'($urandom);
        rq.size  = 2'($urandom);
        rq.sgn   = 1'($urandom);
        rq.wra   = 5'($urandom);
        rq.addr  = $urandom & 32'hFFFF_F03F;
        rq.wd    = $urandom;
        run_op(k, rq, rs, nst);
        check_model(k, rq, rs, nst);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
